// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use hazard detection, write-back bypass on
// capture, and EX/MEM + MEM/WB operand forwarding feeding the ALU directly.
//
// Flow control: id_valid marks a real instruction in ID. When stall is high the
// upstream stages must hold PC and IF/ID so the same instruction is presented
// again next cycle. A bubble is loaded into EX in its place. ex_valid marks a
// real instruction in EX. Bubbles carry NOP_OP, NO_REG and zero controls, so
// anything downstream may ignore their data fields.
module id_ex_operand_stage #(
  parameter int unsigned       DATA_W = 16,
  parameter int unsigned       RA_W   = 4,
  parameter int unsigned       OP_W   = 4,
  parameter logic [OP_W-1:0]   NOP_OP = 4'hD,
  parameter logic [RA_W-1:0]   NO_REG = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_op,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [DATA_W-1:0] id_rs_val,
  input  logic [DATA_W-1:0] id_rt_val,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic              exmem_mem_read,
  input  logic [RA_W-1:0]   exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [RA_W-1:0]   memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              stall,
  output logic              ex_valid,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [RA_W-1:0]   ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write
);

  // Latched operand state for the instruction in EX.
  logic [RA_W-1:0]   ex_rs;
  logic [RA_W-1:0]   ex_rt;
  logic [DATA_W-1:0] ex_rs_val;
  logic [DATA_W-1:0] ex_rt_val;
  logic [DATA_W-1:0] ex_imm;
  logic              ex_use_imm;

  // Capture-time values after the write-back bypass.
  logic [DATA_W-1:0] cap_rs_val;
  logic [DATA_W-1:0] cap_rt_val;
  logic              load_bubble;

  // Forwarded operands.
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  // Load-use hazard: a load in EX whose destination the ID instruction reads.
  // The bubble it creates has mem_read=0, so a second stall cannot follow.
  always_comb begin
    stall = id_valid & ~flush & ex_valid & ex_mem_read & (ex_rd != NO_REG)
          & ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
  end

  // Write-back bypass: a register written by MEM/WB this cycle is read stale
  // from the register file, so take the write data instead.
  always_comb begin
    load_bubble = flush | stall | ~id_valid;
    cap_rs_val  = id_rs_val;
    cap_rt_val  = id_rt_val;
    if (memwb_reg_write && (memwb_rd != NO_REG) && (memwb_rd == id_rs))
      cap_rs_val = memwb_result;
    if (memwb_reg_write && (memwb_rd != NO_REG) && (memwb_rd == id_rt))
      cap_rt_val = memwb_result;
  end

  // ID/EX register: bubble on flush/stall/empty ID, otherwise capture ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      alu_op       <= NOP_OP;
      ex_rd        <= NO_REG;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rs_val    <= '0;
      ex_rt_val    <= '0;
      ex_imm       <= '0;
      ex_use_imm   <= 1'b0;
    end else if (load_bubble) begin
      ex_valid     <= 1'b0;
      alu_op       <= NOP_OP;
      ex_rd        <= NO_REG;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else begin
      ex_valid     <= 1'b1;
      alu_op       <= id_op;
      ex_rd        <= id_rd;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
      ex_mem_write <= id_mem_write;
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_rs_val    <= cap_rs_val;
      ex_rt_val    <= cap_rt_val;
      ex_imm       <= id_imm;
      ex_use_imm   <= id_use_imm;
    end
  end

  // Operand forwarding: EX/MEM (non-load) beats MEM/WB beats latched value.
  // NO_REG is never a forwarding source.
  always_comb begin
    fwd_rs = ex_rs_val;
    fwd_rt = ex_rt_val;
    if (exmem_reg_write && !exmem_mem_read && (exmem_rd == ex_rs) && (ex_rs != NO_REG))
      fwd_rs = exmem_result;
    else if (memwb_reg_write && (memwb_rd == ex_rs) && (ex_rs != NO_REG))
      fwd_rs = memwb_result;
    if (exmem_reg_write && !exmem_mem_read && (exmem_rd == ex_rt) && (ex_rt != NO_REG))
      fwd_rt = exmem_result;
    else if (memwb_reg_write && (memwb_rd == ex_rt) && (ex_rt != NO_REG))
      fwd_rt = memwb_result;
  end

  // ALU operand select.
  always_comb begin
    alu_a         = fwd_rs;
    alu_b         = ex_use_imm ? ex_imm : fwd_rt;
    ex_store_data = fwd_rt;
  end

endmodule
